// File: rtl/bip_pkg.sv
// Shared encodings and default widths for the BIP datapath, control unit and decoder.
// Optional feature macro used by this block family: BIP_DATAPATH_OVF_EN (sticky signed-overflow flag).
package bip_pkg;

  localparam int DEF_NBITS_D = 16;
  localparam int DEF_NBITS_O = 11;
  localparam int DEF_NBITS_C = 16;

  typedef enum logic [1:0] {
    SELA_MEM  = 2'd0,
    SELA_IMM  = 2'd1,
    SELA_ALU  = 2'd2,
    SELA_RSVD = 2'd3
  } sela_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/bip_datapath_if.sv
// Bus between the BIP control unit (master) and the datapath (slave).
// With BIP_DATAPATH_OVF_EN defined the bus also carries the sticky overflow flag o_Ovf.
interface bip_datapath_if #(
  parameter int NBITS_D = 16,
  parameter int NBITS_O = 11,
  parameter int NBITS_C = 16
);

  logic [1:0]         i_SelA;
  logic               i_SelB;
  logic               i_WrAcc;
  logic               i_Op;
  logic [NBITS_O-1:0] i_Operand;
  logic               i_Halt;
  logic [NBITS_D-1:0] i_MemData;
  logic [NBITS_D-1:0] o_MemData;
  logic [NBITS_D-1:0] o_Acc;
  logic               o_Zero;
  logic               o_Halted;
  logic [NBITS_C-1:0] o_InstrCnt;
`ifdef BIP_DATAPATH_OVF_EN
  logic               o_Ovf;
`endif

  modport master (
    output i_SelA, i_SelB, i_WrAcc, i_Op, i_Operand, i_Halt, i_MemData,
`ifdef BIP_DATAPATH_OVF_EN
    input  o_Ovf,
`endif
    input  o_MemData, o_Acc, o_Zero, o_Halted, o_InstrCnt
  );

  modport slave (
    input  i_SelA, i_SelB, i_WrAcc, i_Op, i_Operand, i_Halt, i_MemData,
`ifdef BIP_DATAPATH_OVF_EN
    output o_Ovf,
`endif
    output o_MemData, o_Acc, o_Zero, o_Halted, o_InstrCnt
  );

endinterface

// File: rtl/bip_alu.sv
// Combinational add/subtract unit for the BIP accumulator; carry out of the top bit is dropped.
// With BIP_DATAPATH_OVF_EN defined it also reports signed overflow of the result.
module bip_alu
  import bip_pkg::*;
#(
  parameter int NBITS_D = DEF_NBITS_D
) (
  input  logic [NBITS_D-1:0] i_A,
  input  logic [NBITS_D-1:0] i_B,
  input  logic               i_Op,
`ifdef BIP_DATAPATH_OVF_EN
  output logic               o_Ovf,
`endif
  output logic [NBITS_D-1:0] o_Result
);

  // Add or subtract at the datapath width, wrapping modulo 2^NBITS_D
  always_comb begin
    if (i_Op == OP_SUB) o_Result = i_A - i_B;
    else                o_Result = i_A + i_B;
  end

`ifdef BIP_DATAPATH_OVF_EN
  // Signed overflow: operands effectively share a sign but the result sign differs from A
  always_comb begin
    if (i_Op == OP_SUB)
      o_Ovf = (i_A[NBITS_D-1] != i_B[NBITS_D-1]) && (o_Result[NBITS_D-1] != i_A[NBITS_D-1]);
    else
      o_Ovf = (i_A[NBITS_D-1] == i_B[NBITS_D-1]) && (o_Result[NBITS_D-1] != i_A[NBITS_D-1]);
  end
`endif

endmodule

// File: rtl/bip_datapath.sv
// BIP datapath: accumulator, operand sign extension, ALU, sticky halt and saturating
// executed-instruction counter. Optional macro BIP_DATAPATH_OVF_EN adds a sticky o_Ovf flag.
module bip_datapath
  import bip_pkg::*;
#(
  parameter int NBITS_D = DEF_NBITS_D,
  parameter int NBITS_O = DEF_NBITS_O,
  parameter int NBITS_C = DEF_NBITS_C
) (
  input  logic          i_clk,
  input  logic          i_reset,
  bip_datapath_if.slave bus
);

  logic [NBITS_D-1:0] acc;
  logic [NBITS_D-1:0] ext_operand;
  logic [NBITS_D-1:0] alu_b;
  logic [NBITS_D-1:0] alu_result;
  logic [NBITS_C-1:0] instr_cnt;
  logic               halted;
  logic               wr_accepted;
`ifdef BIP_DATAPATH_OVF_EN
  logic               alu_ovf;
  logic               ovf;
`endif

  assign ext_operand = {{(NBITS_D-NBITS_O){bus.i_Operand[NBITS_O-1]}}, bus.i_Operand};
  assign alu_b       = bus.i_SelB ? ext_operand : bus.i_MemData;
  assign wr_accepted = bus.i_WrAcc && !halted && !bus.i_Halt;

  bip_alu #(.NBITS_D(NBITS_D)) u_alu (
    .i_A      (acc),
    .i_B      (alu_b),
    .i_Op     (bus.i_Op),
`ifdef BIP_DATAPATH_OVF_EN
    .o_Ovf    (alu_ovf),
`endif
    .o_Result (alu_result)
  );

  // Accumulator load from the selected source; reserved select and halt leave it untouched
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc <= '0;
    end else if (wr_accepted) begin
      case (bus.i_SelA)
        SELA_MEM: acc <= bus.i_MemData;
        SELA_IMM: acc <= ext_operand;
        SELA_ALU: acc <= alu_result;
        default:  acc <= acc;
      endcase
    end
  end

  // Halt is sticky until reset
  always_ff @(posedge i_clk) begin
    if (i_reset)                halted <= 1'b0;
    else if (bus.i_Halt)        halted <= 1'b1;
  end

  // Count every non-halted cycle (the halt cycle included), saturating at all ones
  always_ff @(posedge i_clk) begin
    if (i_reset)
      instr_cnt <= '0;
    else if (!halted && (instr_cnt != {NBITS_C{1'b1}}))
      instr_cnt <= instr_cnt + 1'b1;
  end

`ifdef BIP_DATAPATH_OVF_EN
  // Sticky signed overflow, set only when an ALU result actually lands in the accumulator
  always_ff @(posedge i_clk) begin
    if (i_reset)
      ovf <= 1'b0;
    else if (wr_accepted && (bus.i_SelA == SELA_ALU) && alu_ovf)
      ovf <= 1'b1;
  end

  assign bus.o_Ovf = ovf;
`endif

  assign bus.o_Acc      = acc;
  assign bus.o_MemData  = acc;
  assign bus.o_Zero     = (acc == '0);
  assign bus.o_Halted   = halted;
  assign bus.o_InstrCnt = instr_cnt;

endmodule
